// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and helpers for the UART frame decoder and its bench.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LENGTH,
    PAYLOAD,
    CHECKSUM,
    DRAIN
  } frame_state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Checksum byte that makes (len + payload_sum + cs) wrap to zero.
  function automatic logic [7:0] frame_checksum(input logic [7:0] len,
                                                input logic [7:0] payload_sum);
    return 8'(8'h00 - len - payload_sum);
  endfunction

endpackage

// File: rtl/uart_frame_decoder_if.sv
// uart_frame_decoder_if: byte-in / payload-out valid-ready handshakes of the frame decoder.
interface uart_frame_decoder_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_bits;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_bits;
  logic       out_last;

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bits, out_last
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bits, out_last
  );

endinterface

// File: rtl/uart_frame_buffer.sv
// uart_frame_buffer: payload store with one write port and one registered read port.
module uart_frame_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: hunts for a sync byte, parses LEN/payload/CS frames, releases verified payload.
// Optional inter-byte timeout is built only when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 16,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  uart_frame_decoder_if.slave bus,
  output logic                frame_ok,
  output logic                checksum_error,
  output logic                length_error,
  output logic                timeout_error
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_frame_decoder: parameter out of range");
  end

  frame_state_e  state;
  logic [CW-1:0] len;
  logic [CW-1:0] wr;
  logic [CW-1:0] rd;
  logic [7:0]    sum;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          in_accept;
  logic          out_accept;
  logic          timeout_hit;
  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  assign in_accept  = bus.in_valid && in_ready_q;
  assign out_accept = out_valid_q && bus.out_ready;
  assign wr_en      = (state == PAYLOAD) && in_accept;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_bits  = out_valid_q ? rd_data : 8'h00;

  // Read address runs one ahead on a handshake for full-rate drain, and parks at 0
  // otherwise so buf[0] is already on the RAM output when the checksum passes.
  always_comb begin
    rd_addr = '0;
    if (state == DRAIN && !(out_accept && out_last_q)) begin
      rd_addr = out_accept ? AW'(rd + CW'(1)) : AW'(rd);
    end
  end

  uart_frame_buffer #(
    .DEPTH  (MAX_PAYLOAD),
    .ADDR_W (AW)
  ) u_buffer (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (AW'(wr)),
    .wr_data (bus.in_bits),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cycles;
  logic          frame_active;

  assign frame_active = (state == LENGTH) || (state == PAYLOAD) || (state == CHECKSUM);
  assign timeout_hit  = frame_active && !in_accept && (idle_cycles == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_cycles   <= '0;
      timeout_error <= 1'b0;
    end else begin
      timeout_error <= timeout_hit;
      if (!frame_active || in_accept || timeout_hit) idle_cycles <= '0;
      else                                           idle_cycles <= idle_cycles + TW'(1);
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign timeout_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      len            <= '0;
      wr             <= '0;
      rd             <= '0;
      sum            <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      frame_ok       <= 1'b0;
      checksum_error <= 1'b0;
      length_error   <= 1'b0;
    end else begin
      frame_ok       <= 1'b0;
      checksum_error <= 1'b0;
      length_error   <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_accept && bus.in_bits == SYNC_BYTE) state <= LENGTH;
        end
        LENGTH: begin
          if (in_accept) begin
            if (bus.in_bits == 8'h00 || int'(bus.in_bits) > MAX_PAYLOAD) begin
              length_error <= 1'b1;
              state        <= IDLE;
            end else begin
              len   <= CW'(bus.in_bits);
              sum   <= bus.in_bits;
              wr    <= '0;
              state <= PAYLOAD;
            end
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        PAYLOAD: begin
          if (in_accept) begin
            sum <= 8'(sum + bus.in_bits);
            wr  <= wr + CW'(1);
            if (wr == len - CW'(1)) state <= CHECKSUM;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        CHECKSUM: begin
          if (in_accept) begin
            if (8'(sum + bus.in_bits) == 8'h00) begin
              frame_ok    <= 1'b1;
              rd          <= '0;
              out_valid_q <= 1'b1;
              out_last_q  <= (len == CW'(1));
              in_ready_q  <= 1'b0;
              state       <= DRAIN;
            end else begin
              checksum_error <= 1'b1;
              state          <= IDLE;
            end
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (out_accept) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              state       <= IDLE;
            end else begin
              rd         <= rd + CW'(1);
              out_last_q <= ((rd + CW'(1)) == (len - CW'(1)));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: directed frames checked every cycle against a queue-based frame model.
// Timeout scenario is compiled only when UART_FRAME_TIMEOUT_EN is defined.
module tb_uart_frame_decoder;
  import uart_frame_pkg::*;

  localparam int         MaxPayload    = 16;
  localparam logic [7:0] Sync          = 8'hA5;
  localparam int         TimeoutCycles = 1024;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } out_beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic frame_ok;
  logic checksum_error;
  logic length_error;
  logic timeout_error;

  uart_frame_decoder_if bus ();

  uart_frame_decoder #(
    .MAX_PAYLOAD    (MaxPayload),
    .SYNC_BYTE      (Sync),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .frame_ok       (frame_ok),
    .checksum_error (checksum_error),
    .length_error   (length_error),
    .timeout_error  (timeout_error)
  );

  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] cur[$];
  out_beat_t  expOut[$];
  bit         expOk, expCs, expLen, expTo;
  int         idleCount;
  bit         armed;
  bit         predRdy, hs;
  int         cyc = 0;

  int         okSeen, csSeen, lenSeen, toSeen;
  logic [7:0] got[$];
  logic       gotLast[$];
  int         lastHsCyc, resumeCyc;
  bit         randomReady = 1'b0;

  logic [7:0] stim[$];
  logic [7:0] expData[$];
  logic       expLast[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Frame-level model: collects accepted bytes and judges a frame once it is complete.
  task automatic modelAccept(input logic [7:0] b);
    int        total;
    out_beat_t beat;
    idleCount = 0;
    if (cur.size() == 0) begin
      if (b == Sync) cur.push_back(b);
      return;
    end
    cur.push_back(b);
    if (cur.size() == 2 && (b == 8'h00 || int'(b) > MaxPayload)) begin
      expLen = 1'b1;
      cur.delete();
    end else if (cur.size() > 2 && cur.size() == int'(cur[1]) + 3) begin
      total = 0;
      for (int i = 1; i < cur.size(); i++) total += int'(cur[i]);
      if (total % 256 == 0) begin
        expOk = 1'b1;
        for (int i = 2; i < cur.size() - 1; i++) begin
          beat.data = cur[i];
          beat.last = (i == cur.size() - 2);
          expOut.push_back(beat);
        end
      end else begin
        expCs = 1'b1;
      end
      cur.delete();
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      checkOutput("reset_in_ready", bus.in_ready, 0);
      checkOutput("reset_out_valid", bus.out_valid, 0);
      checkOutput("reset_out_last", bus.out_last, 0);
      checkOutput("reset_out_bits", bus.out_bits, 0);
      checkOutput("reset_pulses", {frame_ok, checksum_error, length_error, timeout_error}, 0);
      cur.delete();
      expOut.delete();
      {expOk, expCs, expLen, expTo} = '0;
      idleCount = 0;
      armed = 1'b0;
    end else begin
      checkOutput("in_ready", bus.in_ready, armed && expOut.size() == 0);
      if (expOut.size() > 0) begin
        checkOutput("out_valid", bus.out_valid, 1);
        checkOutput("out_bits", bus.out_bits, expOut[0].data);
        checkOutput("out_last", bus.out_last, expOut[0].last);
      end else begin
        checkOutput("out_valid_idle", bus.out_valid, 0);
        checkOutput("out_last_idle", bus.out_last, 0);
      end
      checkOutput("frame_ok", frame_ok, expOk);
      checkOutput("checksum_error", checksum_error, expCs);
      checkOutput("length_error", length_error, expLen);
      checkOutput("timeout_error", timeout_error, expTo);

      if (frame_ok) okSeen++;
      if (checksum_error) csSeen++;
      if (length_error) lenSeen++;
      if (timeout_error) toSeen++;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_bits);
        gotLast.push_back(bus.out_last);
        if (bus.out_last && lastHsCyc < 0) lastHsCyc = cyc;
      end else if (bus.in_valid && bus.in_ready && lastHsCyc >= 0 && resumeCyc < 0) begin
        resumeCyc = cyc;
      end

      predRdy = armed && expOut.size() == 0;
      hs      = expOut.size() > 0 && bus.out_ready;
      {expOk, expCs, expLen, expTo} = '0;
      if (hs) void'(expOut.pop_front());
      if (bus.in_valid && predRdy) begin
        modelAccept(bus.in_bits);
      end else if (cur.size() > 0) begin
`ifdef UART_FRAME_TIMEOUT_EN
        idleCount++;
        if (idleCount == TimeoutCycles) begin
          expTo = 1'b1;
          cur.delete();
          idleCount = 0;
        end
`endif
      end
      armed = 1'b1;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      bus.out_ready = randomReady ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      int budget;
      bit acc;
      budget = 0;
      acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_bits  = bytes[i];
      while (!acc && budget < 400) begin
        @(negedge clock);
        acc = bus.in_ready;
        @(posedge clock);
        #1;
        budget++;
      end
      checkOutput($sformatf("accept_byte%0d", i), acc, 1);
    end
    bus.in_valid = 1'b0;
    bus.in_bits  = 8'h00;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 400 && expOut.size() != 0; i++) idle(1);
    checkOutput("drain_done", expOut.size(), 0);
    idle(2);
  endtask

  task automatic clearObs();
    okSeen = 0; csSeen = 0; lenSeen = 0; toSeen = 0;
    got.delete();
    gotLast.delete();
    lastHsCyc = -1;
    resumeCyc = -1;
  endtask

  task automatic checkCaptured(input string name, input logic [7:0] eData[$], input logic eLast[$]);
    checkOutput({name, "_count"}, got.size(), eData.size());
    for (int i = 0; i < eData.size() && i < got.size(); i++) begin
      checkOutput($sformatf("%s_byte%0d", name, i), got[i], eData[i]);
      checkOutput($sformatf("%s_last%0d", name, i), gotLast[i], eLast[i]);
    end
  endtask

  initial begin
    int sum;
    logic [7:0] b;
    bus.in_valid = 1'b0;
    bus.in_bits  = 8'h00;
    clearObs();
    idle(3);
    reset = 1'b1;
    idle(2);

    checkOutput("pkg_checksum_97", frame_checksum(8'd3, 8'h66), 8'h97);
    checkOutput("pkg_checksum_fb", frame_checksum(8'd2, 8'h03), 8'hFB);

    // Basic good frame.
    clearObs();
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    applyStimulus(stim);
    waitDrain();
    expData = '{8'h11, 8'h22, 8'h33};
    expLast = '{1'b0, 1'b0, 1'b1};
    checkCaptured("good3", expData, expLast);
    checkOutput("good3_ok_count", okSeen, 1);
    checkOutput("good3_err_count", csSeen + lenSeen + toSeen, 0);

    // Bad checksum then a good frame.
    clearObs();
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98, 8'hA5, 8'h02, 8'h01, 8'h02, 8'hFB};
    applyStimulus(stim);
    waitDrain();
    expData = '{8'h01, 8'h02};
    expLast = '{1'b0, 1'b1};
    checkCaptured("badcs", expData, expLast);
    checkOutput("badcs_cs_count", csSeen, 1);
    checkOutput("badcs_ok_count", okSeen, 1);

    // Length errors, then a payload byte equal to the sync byte.
    clearObs();
    stim = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'hA5, 8'h5A};
    applyStimulus(stim);
    waitDrain();
    expData = '{8'hA5};
    expLast = '{1'b1};
    checkCaptured("lenerr", expData, expLast);
    checkOutput("lenerr_len_count", lenSeen, 2);
    checkOutput("lenerr_ok_count", okSeen, 1);

    // Garbage before sync.
    clearObs();
    stim = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h02, 8'h01, 8'h02, 8'hFB};
    applyStimulus(stim);
    waitDrain();
    expData = '{8'h01, 8'h02};
    expLast = '{1'b0, 1'b1};
    checkCaptured("garbage", expData, expLast);
    checkOutput("garbage_err_count", csSeen + lenSeen, 0);

    // Full-length frame drained under random backpressure with the next frame waiting.
    clearObs();
    randomReady = 1'b1;
    stim.delete();
    expData.delete();
    expLast.delete();
    stim.push_back(Sync);
    stim.push_back(8'd16);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 37 + 5);
      stim.push_back(b);
      expData.push_back(b);
      expLast.push_back(i == 15);
      sum += int'(b);
    end
    stim.push_back(frame_checksum(8'd16, 8'(sum)));
    stim.push_back(8'hA5);
    stim.push_back(8'h01);
    stim.push_back(8'h07);
    stim.push_back(8'hF8);
    expData.push_back(8'h07);
    expLast.push_back(1'b1);
    applyStimulus(stim);
    waitDrain();
    randomReady = 1'b0;
    checkCaptured("full16", expData, expLast);
    checkOutput("full16_ok_count", okSeen, 2);
    checkOutput("full16_resume_gap", resumeCyc - lastHsCyc, 1);

    // Reset mid-payload: outputs drop at once, no pulses, clean decode afterwards.
    clearObs();
    stim = '{8'hA5, 8'h04, 8'h01, 8'h02};
    applyStimulus(stim);
    idle(3);
    reset = 1'b0;
    #1;
    checkOutput("midreset_in_ready", bus.in_ready, 0);
    checkOutput("midreset_out_valid", bus.out_valid, 0);
    idle(3);
    reset = 1'b1;
    idle(2);
    stim = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'hFB};
    applyStimulus(stim);
    waitDrain();
    expData = '{8'h01, 8'h02};
    expLast = '{1'b0, 1'b1};
    checkCaptured("postreset", expData, expLast);
    checkOutput("postreset_ok_count", okSeen, 1);
    checkOutput("postreset_err_count", csSeen + lenSeen + toSeen, 0);

`ifdef UART_FRAME_TIMEOUT_EN
    // Stalled partial frame is abandoned after the timeout.
    clearObs();
    stim = '{8'hA5, 8'h04, 8'h01, 8'h02};
    applyStimulus(stim);
    idle(TimeoutCycles + 10);
    checkOutput("timeout_count", toSeen, 1);
    stim = '{8'hA5, 8'h01, 8'h07, 8'hF8};
    applyStimulus(stim);
    waitDrain();
    expData = '{8'h07};
    expLast = '{1'b1};
    checkCaptured("posttimeout", expData, expLast);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
